// File: rtl/core_sequencer.sv
// core_sequencer -- drives the core instruction word through one full
// weight/activation pass: host words are written into xmem, weights are
// moved into L0 and loaded into the PE array, the pipeline is padded,
// activations are moved into L0 and executed, and the output FIFO is
// drained into psum memory.
//
// Optional feature: define SEQ_STALL_CNT_EN to add the stall_cnt output,
// a saturating count of L0-transfer cycles that were blocked by L0_full.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   start             one-cycle kick-off pulse, only honoured in IDLE
//   n_w, n_a          weight / activation word counts
//   x_base, p_base    xmem and psum base addresses
//   host_data/valid   host write stream, accepted while host_ready is high
//   ofifo_valid       output FIFO has data
//   L0_full           L0 cannot accept another word
//   inst              34-bit core instruction word
//   D_xmem            xmem write data
//   busy, done        activity flag and one-cycle completion pulse
//   stall_cnt         (SEQ_STALL_CNT_EN only) L0 stall cycle counter
//
// State table
//   state   | meaning
//   IDLE    | waiting for start
//   LOAD_X  | host words written into xmem (weights then activations)
//   W_L0    | weights read from xmem into L0
//   K_LOAD  | weights loaded from L0 into the PE array
//   K_PAD   | pipeline settle gap of col cycles
//   A_L0    | activations read from xmem into L0
//   EXEC    | activations streamed from L0 into the array
//   DRAIN   | output FIFO written into psum memory
//   DONE    | completion pulse

module core_sequencer #(
    parameter int bw  = 4,
    parameter int row = 8,
    parameter int col = 8,
    parameter int AW  = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [AW-1:0]     n_w,
    input  logic [AW-1:0]     n_a,
    input  logic [AW-1:0]     x_base,
    input  logic [AW-1:0]     p_base,
    input  logic [bw*row-1:0] host_data,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic              ofifo_valid,
    input  logic              L0_full,
    output logic [33:0]       inst,
    output logic [bw*row-1:0] D_xmem,
    output logic              busy,
    output logic              done
`ifdef SEQ_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_LOAD_X = 4'd1;
    localparam logic [3:0] S_W_L0   = 4'd2;
    localparam logic [3:0] S_K_LOAD = 4'd3;
    localparam logic [3:0] S_K_PAD  = 4'd4;
    localparam logic [3:0] S_A_L0   = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_DRAIN  = 4'd7;
    localparam logic [3:0] S_DONE   = 4'd8;

    // CEN/WEN of both memories high, everything else low
    localparam logic [33:0] IDLE_INST = 34'h1_800C_0000;

    logic [3:0]    state;
    logic [AW-1:0] n_w_q;
    logic [AW-1:0] n_a_q;
    logic [AW-1:0] x_base_q;
    logic [AW-1:0] p_base_q;
    logic [AW:0]   k;        // host words written; can exceed 2^AW-1
    logic [AW-1:0] j;        // L0 reads issued in the current transfer
    logic [AW-1:0] m;        // psum words written
    logic [AW-1:0] tmr;      // down-counter for K_LOAD / K_PAD / EXEC
    logic          rd_pend;  // xmem read issued last cycle, data lands in L0 now

    logic [AW:0]   total;
    logic          in_l0;
    logic [AW-1:0] l0_n;
    logic [AW-1:0] l0_off;
    logic          hs;
    logic          rd_issue;
    logic          l0_last;
    logic          p_wr;
    logic          tmr_tc;

    assign total    = {1'b0, n_w_q} + {1'b0, n_a_q};
    assign in_l0    = (state == S_W_L0) || (state == S_A_L0);
    assign l0_n     = (state == S_W_L0) ? n_w_q : n_a_q;
    assign l0_off   = (state == S_W_L0) ? '0 : n_w_q;
    assign hs       = (state == S_LOAD_X) && host_valid;
    assign rd_issue = in_l0 && !L0_full && (j != l0_n);
    // final L0 write of the transfer: every read issued, last one landing now
    assign l0_last  = in_l0 && rd_pend && (j == l0_n);
    assign p_wr     = (state == S_DRAIN) && ofifo_valid;
    assign tmr_tc   = (tmr == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            n_w_q    <= '0;
            n_a_q    <= '0;
            x_base_q <= '0;
            p_base_q <= '0;
            k        <= '0;
            j        <= '0;
            m        <= '0;
            tmr      <= '0;
            rd_pend  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        n_w_q    <= n_w;
                        n_a_q    <= n_a;
                        x_base_q <= x_base;
                        p_base_q <= p_base;
                        k        <= '0;
                        j        <= '0;
                        m        <= '0;
                        rd_pend  <= 1'b0;
                        if ((n_w == '0) || (n_a == '0))
                            state <= S_DONE;
                        else
                            state <= S_LOAD_X;
                    end
                end
                S_LOAD_X: begin
                    if (hs) begin
                        k <= k + 1'b1;
                        if ((k + 1'b1) == total) begin
                            state   <= S_W_L0;
                            j       <= '0;
                            rd_pend <= 1'b0;
                        end
                    end
                end
                S_W_L0, S_A_L0: begin
                    rd_pend <= rd_issue;
                    if (rd_issue)
                        j <= j + 1'b1;
                    if (l0_last) begin
                        j <= '0;
                        if (state == S_W_L0) begin
                            state <= S_K_LOAD;
                            tmr   <= n_w_q - 1'b1;
                        end else begin
                            state <= S_EXEC;
                            tmr   <= n_a_q - 1'b1;
                        end
                    end
                end
                S_K_LOAD: begin
                    if (tmr_tc) begin
                        state <= S_K_PAD;
                        tmr   <= AW'(col - 1);
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                S_K_PAD: begin
                    if (tmr_tc) begin
                        state   <= S_A_L0;
                        j       <= '0;
                        rd_pend <= 1'b0;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                S_EXEC: begin
                    if (tmr_tc) begin
                        state <= S_DRAIN;
                        m     <= '0;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (p_wr) begin
                        m <= m + 1'b1;
                        if (m == (n_a_q - 1'b1))
                            state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SEQ_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt <= '0;
        else if ((state == S_IDLE) && start)
            stall_cnt <= '0;
        else if (in_l0 && L0_full && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

    // Outputs are decoded from the current state and inputs so that a
    // handshake or stall takes effect in the same cycle; reset masks them
    // immediately rather than waiting for the state register.
    always_comb begin
        inst       = IDLE_INST;
        D_xmem     = '0;
        host_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        if (!reset) begin
            busy       = (state != S_IDLE);
            done       = (state == S_DONE);
            host_ready = (state == S_LOAD_X);
            if (hs) begin
                inst[19]   = 1'b0;
                inst[18]   = 1'b0;
                inst[17:7] = x_base_q + k[AW-1:0];
                D_xmem     = host_data;
            end
            if (rd_issue) begin
                inst[19]   = 1'b0;
                inst[17:7] = x_base_q + l0_off + j;
            end
            if (in_l0 && rd_pend)
                inst[2] = 1'b1;
            if (state == S_K_LOAD) begin
                inst[3] = 1'b1;
                inst[0] = 1'b1;
            end
            if (state == S_EXEC) begin
                inst[3] = 1'b1;
                inst[1] = 1'b1;
            end
            if (p_wr) begin
                inst[32]    = 1'b0;
                inst[31]    = 1'b0;
                inst[30:20] = p_base_q + m;
                inst[6]     = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_core_sequencer.sv
// Testbench for core_sequencer. Expected xmem writes, xmem reads and psum
// writes are queued when an operation is launched; a monitor on the falling
// edge pops and compares each access the DUT presents, and checks the
// cycle rules (read-to-l0_wr latency, pad length, stall behaviour).
// Optional SEQ_STALL_CNT_EN adds stall_cnt checks.

module tb_core_sequencer;

    localparam int BW  = 4;
    localparam int ROW = 8;
    localparam int COL = 8;
    localparam int AW  = 11;
    localparam int DW  = BW * ROW;
    localparam logic [33:0] IDLE_INST = 34'h1_800C_0000;

    logic          clk;
    logic          reset;
    logic          start;
    logic [AW-1:0] n_w, n_a, x_base, p_base;
    logic [DW-1:0] host_data;
    logic          host_valid;
    logic          host_ready;
    logic          ofifo_valid;
    logic          L0_full;
    logic [33:0]   inst;
    logic [DW-1:0] D_xmem;
    logic          busy;
    logic          done;
`ifdef SEQ_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    core_sequencer #(.bw(BW), .row(ROW), .col(COL), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .n_w        (n_w),
        .n_a        (n_a),
        .x_base     (x_base),
        .p_base     (p_base),
        .host_data  (host_data),
        .host_valid (host_valid),
        .host_ready (host_ready),
        .ofifo_valid(ofifo_valid),
        .L0_full    (L0_full),
        .inst       (inst),
        .D_xmem     (D_xmem),
        .busy       (busy),
        .done       (done)
`ifdef SEQ_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } xw_t;

    xw_t           q_xw[$];
    logic [AW-1:0] q_xr[$];
    logic [AW-1:0] q_pw[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc_n = 0;
    bit mon_en = 0;

    // monitor bookkeeping
    int  loads, execs, load_runs, exec_runs, dones;
    int  last_load, pad_stall;
    bit  after_load, prev_rd, prev_load, prev_exec;
    bit  m_xw, m_xr, m_pw;
    xw_t e;
    logic [AW-1:0] ea;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    task automatic flag(input string name, input logic [63:0] act);
        vectors++;
        miscompares++;
        $display("FAIL %s: got %0h, none expected (cycle %0d)", name, act, cyc_n);
    endtask

    task automatic clear_model();
        q_xw.delete();
        q_xr.delete();
        q_pw.delete();
        loads = 0; execs = 0; load_runs = 0; exec_runs = 0; dones = 0;
        after_load = 0; pad_stall = 0; last_load = 0;
    endtask

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            cyc_n++;
            if (mon_en) begin
                m_xw = !inst[19] && !inst[18];
                m_xr = !inst[19] && inst[18];
                m_pw = !inst[32] && !inst[31];
                chk("fixed_zero_fields", {61'd0, inst[33], inst[5], inst[4]}, 64'd0);

                if (m_xw) begin
                    if (q_xw.size() == 0) flag("xw_extra", inst[17:7]);
                    else begin
                        e = q_xw.pop_front();
                        chk("xw_addr", inst[17:7], e.a);
                        chk("xw_data", D_xmem, e.d);
                        chk("xw_on_valid", host_valid, 1'b1);
                    end
                end else begin
                    chk("d_xmem_idle", D_xmem, '0);
                end
                if (!m_xw && !m_xr) chk("a_xmem_idle", inst[17:7], '0);

                if (after_load && !inst[0] && (cyc_n > last_load + COL) && L0_full)
                    pad_stall++;
                if (m_xr) begin
                    if (q_xr.size() == 0) flag("xr_extra", inst[17:7]);
                    else begin
                        ea = q_xr.pop_front();
                        chk("xr_addr", inst[17:7], ea);
                    end
                    chk("xr_while_full", L0_full, 1'b0);
                    if (after_load) begin
                        chk("pad_gap", cyc_n - last_load, COL + 1 + pad_stall);
                        after_load = 0;
                    end
                end
                chk("l0_wr_latency", inst[2], prev_rd);
                prev_rd = m_xr;

                if (inst[0]) begin
                    loads++;
                    if (!prev_load) load_runs++;
                    last_load = cyc_n;
                    after_load = 1;
                    pad_stall = 0;
                end
                if (inst[1]) begin
                    execs++;
                    if (!prev_exec) exec_runs++;
                end
                chk("l0_rd_with_load_exec", inst[3], inst[0] | inst[1]);
                prev_load = inst[0];
                prev_exec = inst[1];

                if (m_pw) begin
                    if (q_pw.size() == 0) flag("pw_extra", inst[30:20]);
                    else begin
                        ea = q_pw.pop_front();
                        chk("pw_addr", inst[30:20], ea);
                    end
                    chk("pw_ofifo_rd", inst[6], 1'b1);
                    chk("pw_on_ofifo_valid", ofifo_valid, 1'b1);
                end else begin
                    chk("ofifo_rd_idle", inst[6], 1'b0);
                    chk("a_pmem_idle", inst[30:20], '0);
                end

                if (done) begin
                    dones++;
                    chk("done_with_busy", busy, 1'b1);
                end
            end
        end
    end

    // hv: 0 always valid, 1 toggle, 2 random
    // lf: 0 never full, 1 four-cycle stall early in W_L0, 2 random
    // ov: 0 always valid, 2 random
    task automatic run_op(input int nw, input int na, input logic [AW-1:0] xb,
                          input logic [AW-1:0] pb, input int hv, input int lf,
                          input int ov, input bit abort);
        logic [DW-1:0] data[$];
        logic [DW-1:0] d;
        int idx, wl0, nexec, cyc;
        bit fin, aborted;

        clear_model();
        for (int i = 0; i < nw + na; i++) begin
            d = $urandom;
            data.push_back(d);
            q_xw.push_back('{a: AW'((int'(xb) + i) % 2048), d: d});
        end
        for (int i = 0; i < nw; i++) q_xr.push_back(AW'((int'(xb) + i) % 2048));
        for (int i = 0; i < na; i++) q_xr.push_back(AW'((int'(xb) + nw + i) % 2048));
        for (int i = 0; i < na; i++) q_pw.push_back(AW'((int'(pb) + i) % 2048));

        n_w = AW'(nw); n_a = AW'(na); x_base = xb; p_base = pb;
        host_data = data[0]; host_valid = 1'b0; L0_full = 1'b0; ofifo_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        chk("busy_before_start", busy, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;

        idx = 0; wl0 = 1_000_000; nexec = 0; fin = 0; aborted = 0;
        for (cyc = 0; cyc < 4000 && !fin; cyc++) begin
            host_data   = (idx < data.size()) ? data[idx] : DW'($urandom);
            host_valid  = (hv == 0) ? 1'b1 : (hv == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 3) != 0);
            L0_full     = (lf == 1) ? (cyc >= wl0 + 2 && cyc < wl0 + 6) :
                          (lf == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
            ofifo_valid = (ov == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            start       = (hv == 2) && ($urandom_range(0, 15) == 0);
            if (abort && nexec == 3) reset = 1'b1;
            @(negedge clk);
`ifdef SEQ_STALL_CNT_EN
            if (cyc == 0) chk("stall_cnt_cleared", stall_cnt, 16'd0);
`endif
            if (reset) begin
                chk("abort_inst", inst, IDLE_INST);
                chk("abort_busy", busy, 1'b0);
                chk("abort_done", done, 1'b0);
                aborted = 1;
                fin = 1;
            end else begin
                if (host_valid && host_ready) begin
                    idx++;
                    if (idx == nw + na) wl0 = cyc + 1;
                end
                if (inst[1]) nexec++;
                if (done) fin = 1;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        host_valid = 1'b0;
        L0_full = 1'b0;
        ofifo_valid = 1'b0;

        if (!fin) begin
            flag("run_timeout", cyc);
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            clear_model();
        end else if (aborted) begin
            reset = 1'b0;
            clear_model();
            @(negedge clk);
            chk("after_abort_inst", inst, IDLE_INST);
            chk("after_abort_busy", busy, 1'b0);
            repeat (20) @(posedge clk);
            #1;
            chk("abort_no_done", dones, 0);
        end else begin
            @(negedge clk);
            chk("busy_after_done", busy, 1'b0);
            chk("done_one_cycle", done, 1'b0);
            chk("idle_inst_after_done", inst, IDLE_INST);
            chk("xw_missing", q_xw.size(), 0);
            chk("xr_missing", q_xr.size(), 0);
            chk("pw_missing", q_pw.size(), 0);
            chk("load_cycles", loads, nw);
            chk("load_runs", load_runs, 1);
            chk("exec_cycles", execs, na);
            chk("exec_runs", exec_runs, 1);
            chk("done_pulses", dones, 1);
`ifdef SEQ_STALL_CNT_EN
            if (lf == 1) chk("stall_cnt", stall_cnt, 16'd4);
            if (lf == 0) chk("stall_cnt_zero", stall_cnt, 16'd0);
`endif
            @(posedge clk); #1;
        end
    endtask

    task automatic zero_op(input int nw, input int na);
        clear_model();
        n_w = AW'(nw); n_a = AW'(na);
        x_base = AW'($urandom); p_base = AW'($urandom);
        host_valid = 1'b1; ofifo_valid = 1'b1; L0_full = 1'b0;
        start = 1'b1;
        @(negedge clk);
        chk("zero_busy_c0", busy, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("zero_busy_c1", busy, 1'b1);
        chk("zero_done_c1", done, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("zero_busy_c2", busy, 1'b0);
        chk("zero_done_c2", done, 1'b0);
        @(posedge clk); #1;
        host_valid = 1'b0; ofifo_valid = 1'b0;
        chk("zero_done_pulses", dones, 1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0;
        n_w = '0; n_a = '0; x_base = '0; p_base = '0;
        host_data = '0; host_valid = 1'b0; ofifo_valid = 1'b0; L0_full = 1'b0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("reset_inst", inst, IDLE_INST);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_host_ready", host_ready, 1'b0);
        @(posedge clk); #1;
        mon_en = 1;

        run_op(8, 16, 11'h7FC, 11'h010, 0, 0, 0, 0);
        run_op(8, 16, AW'($urandom), AW'($urandom), 0, 1, 0, 0);
        run_op(5, 7, AW'($urandom), AW'($urandom), 1, 0, 2, 0);
        zero_op(6, 0);
        zero_op(0, 3);
        run_op(4, 6, AW'($urandom), AW'($urandom), 0, 0, 0, 1);
        run_op(4, 6, AW'($urandom), AW'($urandom), 0, 0, 0, 0);
        for (int r = 0; r < 6; r++)
            run_op($urandom_range(1, 12), $urandom_range(1, 12), AW'($urandom),
                   AW'($urandom), 2, 2, 2, 0);

        mon_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 Parameters: bw=4 (activation/weight bits); row=8 (L0 rows); col=8 (PE columns); AW=11 (SRAM address bits).
REQ-002 clk  in  1  clock; all state updates on the rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 start  in  1  one-cycle pulse; sampled only in IDLE.
REQ-005 n_w, n_a  in  AW each  weight and activation word counts.
REQ-006 x_base  in  AW  xmem base address; weights occupy x_base.., activations follow directly after.
REQ-007 p_base  in  AW  psum SRAM base address.
REQ-008 host_data  in  bw*row  host write word; host_valid  in  1; host_ready  out  1.
REQ-009 ofifo_valid, L0_full  in  1 each  feedback from the core.
REQ-010 inst  out  34  core instruction word; D_xmem  out  bw*row  xmem write data.
REQ-011 busy  out  1  high outside IDLE; done  out  1  one-cycle completion pulse.
REQ-012 inst fields: [33] acc, [32] CEN_pmem, [31] WEN_pmem, [30:20] A_pmem, [19] CEN_xmem, [18] WEN_xmem, [17:7] A_xmem, [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] load.

Function
REQ-013 Idle inst value: bits 32, 31, 19, 18 = 1; all other bits = 0. The block drives this value in IDLE, K_PAD, DONE and whenever a rule below does not assert a field.
REQ-014 States: IDLE, LOAD_X, W_L0, K_LOAD, K_PAD, A_L0, EXEC, DRAIN, DONE.
REQ-015 IDLE->LOAD_X on start; if n_w==0 or n_a==0, go IDLE->DONE instead. start outside IDLE is ignored.
REQ-016 LOAD_X: host_ready=1. Each host_valid&&host_ready cycle drives CEN_xmem=0, WEN_xmem=0, A_xmem=x_base+k, D_xmem=host_data, and increments k. Non-handshake cycles keep CEN_xmem=1. Exit to W_L0 after n_w+n_a writes.
REQ-017 W_L0: issue read CEN_xmem=0, WEN_xmem=1, A_xmem=x_base+j. Assert l0_wr exactly one cycle after each issued read (SRAM read latency 1).
REQ-018 W_L0 stall: while L0_full=1, issue no new read and hold j. An already-issued read still produces its l0_wr.
REQ-019 W_L0 exits to K_LOAD once the l0_wr for the n_w-th word has been asserted.
REQ-020 K_LOAD: l0_rd=1, load=1 for exactly n_w cycles, then K_PAD.
REQ-021 K_PAD: idle inst for exactly col cycles, then A_L0.
REQ-022 A_L0: same rules as W_L0, with addresses x_base+n_w+j for n_a words; then EXEC.
REQ-023 EXEC: l0_rd=1, execute=1 for exactly n_a cycles, then DRAIN.
REQ-024 DRAIN: in any cycle with ofifo_valid=1, drive ofifo_rd=1, CEN_pmem=0, WEN_pmem=0, A_pmem=p_base+m, and increment m. Exit to DONE after n_a writes.
REQ-025 DONE: done=1 for one cycle, then IDLE.
REQ-026 All address sums wrap modulo 2^AW. D_xmem = 0 except during LOAD_X handshake cycles.
REQ-027 acc, ififo_wr and ififo_rd are always 0.

Reset
REQ-028 reset takes priority over all other inputs. In the same cycle it forces: state=IDLE; counters k, j, m and pipeline flags = 0; inst = idle value; D_xmem=0; host_ready=0; busy=0; done=0.
REQ-029 reset in any state aborts the operation; no partial done pulse is produced.

Configuration
REQ-030 Macro SEQ_STALL_CNT_EN. When defined, add output stall_cnt [15:0]:
- cleared on reset and on start;
- increments each W_L0/A_L0 cycle with L0_full=1;
- saturates at 16'hFFFF.
REQ-031 Without SEQ_STALL_CNT_EN, the port and its logic do not exist; all other behaviour is identical.

Verification
REQ-032 Reset, then idle 5 cycles -> inst=34'h1_800C_0000; busy=0; done=0; host_ready=0.
REQ-033 start with n_w=8, n_a=16, x_base=0x7FC, p_base=0x010; host_valid held high; ofifo_valid tied high in DRAIN:
- 24 xmem writes at A_xmem 0x7FC..0x7FF, then wrapping to 0x000..0x013;
- 8 load cycles; 8 pad cycles; 16 execute cycles;
- psum writes at A_pmem 0x010..0x01F;
- one done pulse.
REQ-034 In W_L0, hold L0_full=1 for 4 cycles -> A_xmem frozen, exactly one trailing l0_wr, resume at the next address; with the macro defined, stall_cnt=4.
REQ-035 host_valid toggling 1,0,1,0 in LOAD_X -> writes only on valid cycles, CEN_xmem=1 on gaps, write count still n_w+n_a.
REQ-036 start with n_a=0 -> busy high for 1 cycle, done at cycle 2; no xmem or pmem access.
REQ-037 reset asserted in EXEC -> next cycle IDLE, idle inst, done never pulses; a following start runs a complete sequence.
